// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 byte stream to RGB565 frame buffer writer
// Single pclk domain: input stage, byte pairing FSM, registered write port.
module ov7670_capture #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int ADDR_W = 19
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              captureEn,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        camData,
  output logic [ADDR_W-1:0] inAddr,
  output logic              writeEn,
  output logic [15:0]       pixelIn,
  output logic              frameDone,
  output logic              frameShort,
  output logic              overflow
);

  localparam logic [ADDR_W:0] PIXELS = (ADDR_W+1)'(WIDTH * HEIGHT);

  typedef enum logic [1:0] {SYNC, BLANK, ACTIVE, SKIP} state_t;

  state_t            state;
  logic              vsyncS1;
  logic              hrefS1;
  logic [7:0]        dataS1;
  logic              phase;
  logic [7:0]        highByte;
  logic [ADDR_W:0]   pixCount;
  logic              pairValid;
  logic [15:0]       pairData;
  logic [ADDR_W-1:0] pairAddr;

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= SYNC;
      vsyncS1    <= 1'b0;
      hrefS1     <= 1'b0;
      dataS1     <= '0;
      phase      <= 1'b0;
      highByte   <= '0;
      pixCount   <= '0;
      pairValid  <= 1'b0;
      pairData   <= '0;
      pairAddr   <= '0;
      inAddr     <= '0;
      writeEn    <= 1'b0;
      pixelIn    <= '0;
      frameDone  <= 1'b0;
      frameShort <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      vsyncS1    <= vsync;
      hrefS1     <= href;
      dataS1     <= camData;
      frameDone  <= 1'b0;
      frameShort <= 1'b0;
      pairValid  <= 1'b0;
      writeEn    <= pairValid;
      if (pairValid) begin
        inAddr  <= pairAddr;
        pixelIn <= pairData;
      end

      case (state)
        SYNC: if (vsyncS1) state <= BLANK;
        BLANK: begin
          if (!vsyncS1) begin
            if (captureEn) begin
              state    <= ACTIVE;
              pixCount <= '0;
              overflow <= 1'b0;
              phase    <= 1'b0;
            end else begin
              state <= SKIP;
            end
          end
        end
        SKIP: if (vsyncS1) state <= BLANK;
        ACTIVE: begin
          if (vsyncS1) begin
            // a half-assembled pair at vsync rise is simply dropped
            state      <= BLANK;
            frameDone  <= 1'b1;
            frameShort <= (pixCount != PIXELS);
            phase      <= 1'b0;
          end else if (!hrefS1) begin
            phase <= 1'b0;
          end else if (!phase) begin
            highByte <= dataS1;
            phase    <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (pixCount < PIXELS) begin
              pairValid <= 1'b1;
              pairData  <= {highByte, dataS1};
              pairAddr  <= pixCount[ADDR_W-1:0];
            end else begin
              overflow <= 1'b1;
            end
            if (pixCount != '1) pixCount <= pixCount + 1'b1;
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
